uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 29 ++
 rtl/uart_tx_fifo_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Contents:
//   state_t      - transmitter FSM states
//   PAR_*        - parity mode selectors for the PARITY parameter
//   parity_bit() - parity bit for a payload word (zero-extended to 9 bits)
package uart_tx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Zero-extension does not change the XOR reduction, so every payload
    // width from 5 to 9 bits can share this one 9-bit helper.
    function automatic logic parity_bit(input logic [8:0] word, input int mode);
        if (mode == PAR_ODD) begin
            return ~^word;
        end
        return ^word;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears pointers)
//   push, din   - write strobe and word; ignored while full
//   pop         - advance the read pointer; ignored while empty
//   dout        - head word, visible before pop
//   full, empty - occupancy flags
//   level       - number of stored words (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB: equal low bits with differing MSBs
    // means full, fully equal means empty. They wrap modulo 2*DEPTH.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal write FIFO.
// Words written through the valid/ready port are queued and serialised
// LSB-first as: start(0), DATA_BITS data, optional parity, STOP_BITS stop(1).
// Queued words go out back-to-back with no idle cycle between frames.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   wr_valid   - write request; accepted when wr_ready is high
//   wr_ready   - FIFO not full (combinational)
//   wr_data    - word to transmit
//   uart_tx    - registered serial output, idles high
//   busy       - FSM is not idle
//   level      - FIFO occupancy
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 baud_end;
    logic                 stop_end;

    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign busy     = (state != ST_IDLE);

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign stop_end = (state == ST_STOP) && baud_end && (bit_cnt == STOP_LAST);

    // The head word leaves the FIFO either when idle or on the very last
    // cycle of the final stop bit, which is what makes frames back-to-back.
    assign pop = !empty && ((state == ST_IDLE) || stop_end);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // uart_tx is always loaded with the value of the bit period that begins
    // on this edge, so the line changes exactly on bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        shreg    <= head;
                        par      <= parity_bit(9'(head), PARITY);
                        uart_tx  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                        uart_tx  <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state   <= ST_PARITY;
                                uart_tx <= par;
                            end else begin
                                state   <= ST_STOP;
                                uart_tx <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state   <= ST_START;
                                shreg   <= head;
                                par     <= parity_bit(9'(head), PARITY);
                                uart_tx <= 1'b0;
                            end else begin
                                state   <= ST_IDLE;
                                uart_tx <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four instances (default, even
// parity, odd parity, 7 data bits with 2 stop bits), a vector table of
// single-word frames, and directed sequences for FIFO fill, back-to-back
// frames and asynchronous reset in mid-frame.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       vld [4];
    logic       rdy [4];
    logic       tx  [4];
    logic       bsy [4];
    logic [2:0] lvl [4];
    logic [7:0] wd  [4];

    uart_tx_fifo dut0 (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld[0]), .wr_ready(rdy[0]),
        .wr_data(wd[0]), .uart_tx(tx[0]), .busy(bsy[0]), .level(lvl[0]));

    uart_tx_fifo #(.PARITY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld[1]), .wr_ready(rdy[1]),
        .wr_data(wd[1]), .uart_tx(tx[1]), .busy(bsy[1]), .level(lvl[1]));

    uart_tx_fifo #(.PARITY(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld[2]), .wr_ready(rdy[2]),
        .wr_data(wd[2]), .uart_tx(tx[2]), .busy(bsy[2]), .level(lvl[2]));

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_valid(vld[3]), .wr_ready(rdy[3]),
        .wr_data(wd[3][6:0]), .uart_tx(tx[3]), .busy(bsy[3]), .level(lvl[3]));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the fill / back-to-back sequence.
    int maxlvl     = 0;
    int busy_gaps  = 0;
    bit mon_busy   = 1'b0;

    always @(negedge clk) begin
        if (int'(lvl[0]) > maxlvl) maxlvl = int'(lvl[0]);
        if (mon_busy && !bsy[0]) busy_gaps = busy_gaps + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int d, input logic [7:0] data);
        @(negedge clk);
        wd[d]  = data;
        vld[d] = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
    endtask

    typedef struct {
        int          d;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] frame;   // bit i = i-th transmitted bit
        int          len;
    } vec_t;

    vec_t vecs [10];

    // Write one word into an idle instance, capture the whole frame and
    // compare the line image and the busy duration with the table entry.
    task automatic run_vec(input vec_t v, input int idx);
        logic        s [400];
        logic [11:0] got;
        int          n;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        for (int i = 0; i < 400; i++) s[i] = 1'b1;
        push_word(v.d, v.data);
        // One half cycle after the accepting edge: not yet popped.
        check({tag, "_pre_tx"},   32'(tx[v.d]),  32'd1);
        check({tag, "_pre_busy"}, 32'(bsy[v.d]), 32'd0);
        check({tag, "_pre_lvl"},  32'(lvl[v.d]), 32'd1);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (!bsy[v.d]) break;
            s[n] = tx[v.d];
            n++;
        end
        got = '0;
        for (int b = 0; b < v.nbits; b++) got[b] = s[b*16 + 8];
        check({tag, "_frame"}, 32'(got), 32'(v.frame));
        check({tag, "_len"},   32'(n),   32'(v.len));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h55, 10, 12'h2AA, 160};
        vecs[1] = '{0, 8'h00, 10, 12'h200, 160};
        vecs[2] = '{0, 8'hFF, 10, 12'h3FE, 160};
        vecs[3] = '{0, 8'hA5, 10, 12'h34A, 160};
        vecs[4] = '{1, 8'h01, 11, 12'h602, 176};
        vecs[5] = '{1, 8'h03, 11, 12'h406, 176};
        vecs[6] = '{2, 8'h01, 11, 12'h402, 176};
        vecs[7] = '{2, 8'h00, 11, 12'h600, 176};
        vecs[8] = '{3, 8'h7F, 10, 12'h3FE, 160};
        vecs[9] = '{3, 8'h2A, 10, 12'h354, 160};

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            wd[i]  = 8'h00;
        end

        // Reset state, while reset is held.
        #12;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst%0d_tx", i),    32'(tx[i]),  32'd1);
            check($sformatf("rst%0d_busy", i),  32'(bsy[i]), 32'd0);
            check($sformatf("rst%0d_lvl", i),   32'(lvl[i]), 32'd0);
            check($sformatf("rst%0d_ready", i), 32'(rdy[i]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_tx",    32'(tx[0]),  32'd1);
        check("post_rst_ready", 32'(rdy[0]), 32'd1);

        // Single-frame vectors.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
            repeat (2) @(negedge clk);
        end

        // Fill the FIFO with A0..A5 while the first frame is in flight and
        // receive all six frames back-to-back.
        maxlvl    = 0;
        busy_gaps = 0;
        fork
            begin : pusher
                int w;
                for (int i = 0; i < 6; i++) begin
                    wd[0]  = 8'hA0 + 8'(i);
                    vld[0] = 1'b1;
                    w = 0;
                    while (!rdy[0] && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    if (i == 5) check("fill_ready_wait", 32'(w), 32'd157);
                    @(negedge clk);
                    if (i == 4) begin
                        check("fill_lvl4",   32'(lvl[0]), 32'd4);
                        check("fill_ready0", 32'(rdy[0]), 32'd0);
                    end
                end
                vld[0] = 1'b0;
            end
            begin : receiver
                int          w;
                int          start;
                int          last;
                logic [9:0]  got;
                last = 0;
                for (int f = 0; f < 6; f++) begin
                    w = 0;
                    while (tx[0] !== 1'b0 && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    check($sformatf("rx%0d_found", f), 32'(w < 400), 32'd1);
                    start = cyc;
                    mon_busy = 1'b1;
                    if (f > 0) check($sformatf("rx%0d_gap", f), 32'(start - last), 32'd160);
                    last = start;
                    repeat (8) @(negedge clk);
                    got[0] = tx[0];
                    for (int b = 1; b < 10; b++) begin
                        repeat (16) @(negedge clk);
                        got[b] = tx[0];
                    end
                    check($sformatf("rx%0d_frame", f), 32'(got),
                          32'({1'b1, 8'hA0 + 8'(f), 1'b0}));
                end
                mon_busy = 1'b0;
            end
        join
        check("fill_maxlvl",    32'(maxlvl),    32'd4);
        check("b2b_busy_gaps",  32'(busy_gaps), 32'd0);
        repeat (20) @(negedge clk);
        check("fill_end_busy", 32'(bsy[0]), 32'd0);
        check("fill_end_lvl",  32'(lvl[0]), 32'd0);

        // Asynchronous reset in the middle of DATA with two words queued.
        push_word(0, 8'h00);
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        repeat (50) @(negedge clk);
        check("mid_tx_low", 32'(tx[0]),  32'd0);
        check("mid_lvl2",   32'(lvl[0]), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx",    32'(tx[0]),  32'd1);
        check("arst_lvl",   32'(lvl[0]), 32'd0);
        check("arst_busy",  32'(bsy[0]), 32'd0);
        check("arst_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int activity;
            activity = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (tx[0] !== 1'b1 || bsy[0] !== 1'b0) activity++;
            end
            check("arst_no_frame", 32'(activity), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
